algo_1rw_a25_refr_sched: RTL and testbench

//  Refresh scheduler for the DRAM bank array behind the 1rw a25 algorithm memory.

---
 rtl/algo_1rw_a25_refr_sched.sv | 170 +++++++++++++++++
 tb/tb_algo_1rw_a25_refr_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/algo_1rw_a25_refr_sched.sv
// Refresh scheduler: spreads one refresh per virtual bank across each epoch and
// steers around user accesses. Optional statistics counters under REFR_STAT_EN.
module algo_1rw_a25_refr_sched #(
  parameter int NUMVBNK = 4,
  parameter int BITVBNK = 2,
  parameter int NUMRROW = 256,
  parameter int BITRROW = 8,
  parameter int REFFREQ = 6,
  parameter int STATW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refr,
  input  logic               acc_vld,
  input  logic [BITVBNK-1:0] acc_bank,
  output logic               acc_stall,
  output logic               t1_refrB,
  output logic [BITVBNK-1:0] t1_bankB,
  output logic [BITRROW-1:0] refr_row,
  output logic               refr_ovf,
  output logic [STATW-1:0]   refr_cnt,
  output logic [STATW-1:0]   stall_cnt
);

  localparam int AGEW = (REFFREQ > 2) ? $clog2(REFFREQ) : 1;
  localparam int SUMW = ((AGEW > BITVBNK + 1) ? AGEW : BITVBNK + 1) + 1;
  localparam logic [AGEW-1:0]    AGEMAX = AGEW'(REFFREQ - 1);
  localparam logic [BITRROW-1:0] ROWMAX = BITRROW'(NUMRROW - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] URGENT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUMVBNK-1:0] pend_q, pend_d;
  logic [BITVBNK-1:0] ptr_q, ptr_d;
  logic [AGEW-1:0]    age_q, age_d;
  logic [BITRROW-1:0] row_q, row_d;
  logic               ovf_q, ovf_d;
  logic               stall_q, stall_d;
  logic               refrb_q;
  logic [BITVBNK-1:0] bankb_q;

  logic               urgent;
  logic               sel_vld;
  logic [BITVBNK-1:0] sel_bank;
  logic [BITVBNK-1:0] idx;
  logic [NUMVBNK-1:0] pend_clr;
  logic [BITVBNK:0]   pop;
  logic [SUMW-1:0]    age_sum;
  logic               urgent_hit;

  assign urgent = (state_q == URGENT);

  // Rotating-priority pick; in URGENT the access bank no longer blocks a refresh.
  always_comb begin
    sel_vld  = 1'b0;
    sel_bank = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NUMVBNK; i++) begin
      idx = ptr_q + BITVBNK'(i);
      if (!sel_vld && pend_q[idx] && !(acc_vld && !urgent && (acc_bank == idx))) begin
        sel_vld  = 1'b1;
        sel_bank = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUMVBNK; i++) begin
      pop = pop + (BITVBNK + 1)'(pend_q[i]);
    end
  end

  // age >= REFFREQ-1-popcount, rearranged to avoid unsigned underflow
  assign age_sum    = SUMW'(age_q) + SUMW'(pop);
  assign urgent_hit = (age_sum >= SUMW'(REFFREQ - 1));

  always_comb begin
    pend_clr = '0;
    if (sel_vld) begin
      pend_clr = NUMVBNK'(1) << sel_bank;
    end
    pend_d = refr ? '1 : (pend_q & ~pend_clr);
    ptr_d  = sel_vld ? (sel_bank + BITVBNK'(1)) : ptr_q;
    ovf_d  = ovf_q | (refr && (pend_q != '0));

    age_d = '0;
    if (!refr && (pend_q != '0)) begin
      age_d = (age_q == AGEMAX) ? age_q : age_q + AGEW'(1);
    end

    row_d = row_q;
    if ((pend_q != '0) && (pend_d == '0)) begin
      row_d = (row_q == ROWMAX) ? '0 : row_q + BITRROW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (refr) state_d = RUN;
      end
      RUN: begin
        if (refr)               state_d = RUN;
        else if (pend_d == '0)  state_d = IDLE;
        else if (urgent_hit)    state_d = URGENT;
      end
      URGENT: begin
        if (!refr && (pend_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_q == URGENT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      age_q   <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
      stall_q <= 1'b0;
      refrb_q <= 1'b0;
      bankb_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      age_q   <= age_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
      stall_q <= stall_d;
      refrb_q <= sel_vld;
      bankb_q <= sel_vld ? sel_bank : '0;
    end
  end

  assign acc_stall = stall_q;
  assign t1_refrB  = refrb_q;
  assign t1_bankB  = bankb_q;
  assign refr_row  = row_q;
  assign refr_ovf  = ovf_q;

`ifdef REFR_STAT_EN
  logic [STATW-1:0] refr_cnt_q;
  logic [STATW-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refr_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (refrb_q && (refr_cnt_q != '1))  refr_cnt_q  <= refr_cnt_q + STATW'(1);
      if (stall_q && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STATW'(1);
    end
  end

  assign refr_cnt  = refr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign refr_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_algo_1rw_a25_refr_sched.sv
// Directed bench for algo_1rw_a25_refr_sched: clean epochs, conflicts, urgent
// completion, epoch overflow, row wrap and reset during urgent.
module tb_algo_1rw_a25_refr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       refr;
  logic       acc_vld;
  logic [1:0] acc_bank;
  logic       acc_stall;
  logic       t1_refrB;
  logic [1:0] t1_bankB;
  logic [7:0] refr_row;
  logic       refr_ovf;
  logic [15:0] refr_cnt;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int proto_viol = 0;

  algo_1rw_a25_refr_sched #(
    .NUMVBNK(4), .BITVBNK(2), .NUMRROW(256), .BITRROW(8), .REFFREQ(6), .STATW(16)
  ) dut (
    .clk(clk), .rst(rst), .refr(refr), .acc_vld(acc_vld), .acc_bank(acc_bank),
    .acc_stall(acc_stall), .t1_refrB(t1_refrB), .t1_bankB(t1_bankB),
    .refr_row(refr_row), .refr_ovf(refr_ovf), .refr_cnt(refr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && acc_vld === 1'b1 && acc_stall === 1'b1) proto_viol++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; refr = 1'b0; acc_vld = 1'b0; acc_bank = 2'd0;
    #2;
    chk("rst_t1_refrB", 32'(t1_refrB), 0);
    chk("rst_t1_bankB", 32'(t1_bankB), 0);
    chk("rst_acc_stall", 32'(acc_stall), 0);
    chk("rst_refr_row", 32'(refr_row), 0);
    chk("rst_refr_ovf", 32'(refr_ovf), 0);
    chk("rst_refr_cnt", 32'(refr_cnt), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    tick();
    rst = 1'b1;

    // Clean epoch: banks 0..3 on cycles 2..5
    refr = 1'b1;
    tick();
    refr = 1'b0;
    chk("s1_idle_c1", 32'(t1_refrB), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_vld", 32'(t1_refrB), 1);
      chk("s1_bank", 32'(t1_bankB), 32'(i));
      chk("s1_stall", 32'(acc_stall), 0);
    end
    chk("s1_row", 32'(refr_row), 1);
    tick();
    chk("s1_done", 32'(t1_refrB), 0);

    // 255 more clean epochs: row wraps 255 -> 0
    for (int e = 0; e < 255; e++) begin
      refr = 1'b1;
      tick();
      refr = 1'b0;
      repeat (5) tick();
      if (e == 253) chk("s5_row255", 32'(refr_row), 255);
    end
    chk("s5_row_wrap", 32'(refr_row), 0);
    chk("s5_stall", 32'(acc_stall), 0);
    chk("s5_ovf", 32'(refr_ovf), 0);
`ifdef REFR_STAT_EN
    chk("s5_refr_cnt", 32'(refr_cnt), 1024);
    chk("s5_stall_cnt", 32'(stall_cnt), 0);
`else
    chk("s5_refr_cnt", 32'(refr_cnt), 0);
    chk("s5_stall_cnt", 32'(stall_cnt), 0);
`endif

    // Access held on bank 0: 1,2,3 issue, then urgent forces bank 0
    acc_vld = 1'b1; acc_bank = 2'd0; refr = 1'b1;
    tick();
    refr = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("s2_vld", 32'(t1_refrB), 1);
      chk("s2_bank", 32'(t1_bankB), 32'(i));
    end
    tick();
    chk("s2_c5_none", 32'(t1_refrB), 0);
    chk("s2_c5_stall", 32'(acc_stall), 0);
    tick();
    chk("s2_c6_none", 32'(t1_refrB), 0);
    chk("s2_c6_stall", 32'(acc_stall), 0);
    tick();
    chk("s2_c7_stall", 32'(acc_stall), 1);
    chk("s2_c7_vld", 32'(t1_refrB), 1);
    chk("s2_c7_bank", 32'(t1_bankB), 0);
    chk("s2_c7_row", 32'(refr_row), 1);
    acc_vld = 1'b0;
    tick();
    chk("s2_c8_stall", 32'(acc_stall), 0);
    chk("s2_c8_none", 32'(t1_refrB), 0);

    // acc_bank on the first eligible bank each cycle; ptr starts at 1
    acc_vld = 1'b1; refr = 1'b1;
    tick();
    refr = 1'b0; acc_bank = 2'd1;
    tick();
    chk("s3_c2_bank", 32'(t1_bankB), 2);
    acc_bank = 2'd3;
    tick();
    chk("s3_c3_bank", 32'(t1_bankB), 0);
    acc_bank = 2'd1;
    tick();
    chk("s3_c4_bank", 32'(t1_bankB), 3);
    chk("s3_c4_vld", 32'(t1_refrB), 1);
    tick();
    chk("s3_c5_none", 32'(t1_refrB), 0);
    tick();
    chk("s3_c6_none", 32'(t1_refrB), 0);
    chk("s3_c6_stall", 32'(acc_stall), 0);
    tick();
    chk("s3_c7_vld", 32'(t1_refrB), 1);
    chk("s3_c7_bank", 32'(t1_bankB), 1);
    chk("s3_c7_stall", 32'(acc_stall), 1);
    acc_vld = 1'b0;
    tick();
    chk("s3_c8_stall", 32'(acc_stall), 0);
    chk("s3_row", 32'(refr_row), 2);

    // Second refr two cycles after the first: overflow, fresh 4 refreshes
    refr = 1'b1;
    tick();
    refr = 1'b0;
    tick();
    chk("s4_c2_bank", 32'(t1_bankB), 2);
    chk("s4_c2_ovf", 32'(refr_ovf), 0);
    refr = 1'b1;
    tick();
    refr = 1'b0;
    chk("s4_c3_bank", 32'(t1_bankB), 3);
    chk("s4_c3_ovf", 32'(refr_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_vld", 32'(t1_refrB), 1);
      chk("s4_bank", 32'(t1_bankB), 32'(i));
      chk("s4_stall", 32'(acc_stall), 0);
    end
    chk("s4_row", 32'(refr_row), 3);
    tick();
    chk("s4_done", 32'(t1_refrB), 0);
    chk("s4_ovf_sticky", 32'(refr_ovf), 1);
`ifdef REFR_STAT_EN
    chk("s4_refr_cnt", 32'(refr_cnt), 1038);
    chk("s4_stall_cnt", 32'(stall_cnt), 2);
`else
    chk("s4_refr_cnt", 32'(refr_cnt), 0);
    chk("s4_stall_cnt", 32'(stall_cnt), 0);
`endif

    // Reset while URGENT with bank 0 still owed
    acc_vld = 1'b1; acc_bank = 2'd0; refr = 1'b1;
    tick();
    refr = 1'b0;
    repeat (5) tick();
    chk("s6_pre_row", 32'(refr_row), 3);
    chk("s6_pre_ovf", 32'(refr_ovf), 1);
    rst = 1'b0;
    #1;
    chk("s6_rst_refrB", 32'(t1_refrB), 0);
    chk("s6_rst_bankB", 32'(t1_bankB), 0);
    chk("s6_rst_stall", 32'(acc_stall), 0);
    chk("s6_rst_row", 32'(refr_row), 0);
    chk("s6_rst_ovf", 32'(refr_ovf), 0);
    chk("s6_rst_refr_cnt", 32'(refr_cnt), 0);
    acc_vld = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s6_no_refresh", 32'(t1_refrB), 0);
    end
    chk("s6_stall_after", 32'(acc_stall), 0);
    chk("s6_row_after", 32'(refr_row), 0);

    chk("protocol_acc_vld_during_stall", 32'(proto_viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
